// File: rtl/mbus_timer.sv
// Programmable timer/counter on the CPU memory bus: prescaled up/down counting,
// auto-reload, compare flag and a level interrupt with combinational read-back.
module mbus_timer #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  localparam logic [AW-1:0] A_CNT  = AW'(0);
  localparam logic [AW-1:0] A_AR   = AW'(1);
  localparam logic [AW-1:0] A_CTRL = AW'(2);
  localparam logic [AW-1:0] A_STAT = AW'(3);
  localparam logic [AW-1:0] A_PRE  = AW'(4);
  localparam logic [AW-1:0] A_CMP  = AW'(5);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] ar_reg, ar_next;
  logic [WIDTH-1:0] pre_reg, pre_next;
  logic [WIDTH-1:0] cmp_reg, cmp_next;
  logic [WIDTH-1:0] pcnt_reg, pcnt_next;
  logic [3:0]       ctrl_reg, ctrl_next;
  logic [1:0]       flag_reg, flag_next, flag_set;

  logic             run, down, irq_en, oneshot;
  logic             wr, wr_cnt, wr_ar, wr_ctrl, wr_stat, wr_pre, wr_cmp;
  logic             tick, wrap, ovf_ev, cmp_ev;
  logic [WIDTH-1:0] cnt_tick;

  assign run     = ctrl_reg[0];
  assign down    = ctrl_reg[1];
  assign irq_en  = ctrl_reg[2];
  assign oneshot = ctrl_reg[3];

  assign wr      = cs & wen;
  assign wr_cnt  = wr && (addr == A_CNT);
  assign wr_ar   = wr && (addr == A_AR);
  assign wr_ctrl = wr && (addr == A_CTRL);
  assign wr_stat = wr && (addr == A_STAT);
  assign wr_pre  = wr && (addr == A_PRE);
  assign wr_cmp  = wr && (addr == A_CMP);

  assign tick = run && (pcnt_reg == pre_reg);

  always_comb begin
    wrap     = 1'b0;
    cnt_tick = cnt_reg;
    if (!down) begin
      wrap     = (cnt_reg == ar_reg);
      cnt_tick = wrap ? '0 : cnt_reg + WIDTH'(1);
    end else begin
      wrap     = (cnt_reg == '0);
      cnt_tick = wrap ? ar_reg : cnt_reg - WIDTH'(1);
    end
  end

  // A bus write to CNT cancels every side effect of a coincident tick.
  assign ovf_ev   = tick && wrap && !wr_cnt;
  assign cmp_ev   = tick && (cnt_tick == cmp_reg) && !wr_cnt;
  assign flag_set = {cmp_ev, ovf_ev};

  always_comb begin
    cnt_next  = wr_cnt ? din : (tick ? cnt_tick : cnt_reg);
    ar_next   = wr_ar  ? din : ar_reg;
    pre_next  = wr_pre ? din : pre_reg;
    cmp_next  = wr_cmp ? din : cmp_reg;
    pcnt_next = pcnt_reg;
    if (wr_pre || tick) begin
      pcnt_next = '0;
    end else if (run) begin
      pcnt_next = pcnt_reg + WIDTH'(1);
    end
    ctrl_next = ctrl_reg;
    if (wr_ctrl) begin
      ctrl_next = din[3:0];
    end else if (ovf_ev && oneshot) begin
      ctrl_next[0] = 1'b0;
    end
  end

  // Set events beat write-one-to-clear on the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
      assign flag_next[gi] = flag_set[gi] | (flag_reg[gi] & ~(wr_stat & din[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      ar_reg   <= '1;
      pre_reg  <= '0;
      cmp_reg  <= '0;
      pcnt_reg <= '0;
      ctrl_reg <= '0;
      flag_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      ar_reg   <= ar_next;
      pre_reg  <= pre_next;
      cmp_reg  <= cmp_next;
      pcnt_reg <= pcnt_next;
      ctrl_reg <= ctrl_next;
      flag_reg <= flag_next;
    end
  end

  always_comb begin
    dout = '0;
    if (cs) begin
      case (addr)
        A_CNT:   dout = cnt_reg;
        A_AR:    dout = ar_reg;
        A_CTRL:  dout = {{(WIDTH-4){1'b0}}, ctrl_reg};
        A_STAT:  dout = {{(WIDTH-2){1'b0}}, flag_reg};
        A_PRE:   dout = pre_reg;
        A_CMP:   dout = cmp_reg;
        default: dout = '0;
      endcase
    end
  end

  assign irq = irq_en & (|flag_reg);

endmodule

// File: tb/tb_mbus_timer.sv
// Scoreboarded random/directed bench for mbus_timer against a behavioural model.
module tb_mbus_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        wen;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  mbus_timer #(.WIDTH(32), .AW(3)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        i;
    logic [2:0]  a;
    logic        c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model state
  logic [31:0] m_cnt, m_ar, m_pre, m_cmp, m_pcnt;
  logic        m_run, m_down, m_ien, m_os, m_ovf, m_cmpf;

  task automatic model_reset();
    m_cnt = 0; m_ar = 32'hFFFF_FFFF; m_pre = 0; m_cmp = 0; m_pcnt = 0;
    m_run = 0; m_down = 0; m_ien = 0; m_os = 0; m_ovf = 0; m_cmpf = 0;
  endtask

  function automatic logic [31:0] model_read(input logic c, input logic [2:0] a);
    if (!c) return 32'h0;
    case (a)
      3'd0:    return m_cnt;
      3'd1:    return m_ar;
      3'd2:    return {28'h0, m_os, m_ien, m_down, m_run};
      3'd3:    return {30'h0, m_cmpf, m_ovf};
      3'd4:    return m_pre;
      3'd5:    return m_cmp;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: queue the expected combinational response, then advance the model over the edge.
  task automatic bus_cycle(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
    logic [31:0] n_cnt, n_ar, n_pre, n_cmp, n_pcnt, v;
    logic        n_run, n_down, n_ien, n_os, n_ovf, n_cmpf;
    logic        tk, ovf_ev, cmp_ev, stop, wr;
    exp_t        e;
    cs = c; wen = w; addr = a; din = d;
    e.d = model_read(c, a); e.i = m_ien & (m_ovf | m_cmpf); e.a = a; e.c = c;
    q.push_back(e);

    n_cnt = m_cnt; n_ar = m_ar; n_pre = m_pre; n_cmp = m_cmp; n_pcnt = m_pcnt;
    n_run = m_run; n_down = m_down; n_ien = m_ien; n_os = m_os;
    n_ovf = m_ovf; n_cmpf = m_cmpf;
    wr = c && w;
    tk = m_run && (m_pcnt == m_pre);
    ovf_ev = 0; cmp_ev = 0; stop = 0;
    if (m_run) n_pcnt = tk ? 32'h0 : m_pcnt + 1;
    if (tk) begin
      if (!m_down) begin
        if (m_cnt == m_ar) begin v = 0; ovf_ev = 1; stop = m_os; end
        else v = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin v = m_ar; ovf_ev = 1; stop = m_os; end
        else v = m_cnt - 1;
      end
      cmp_ev = (v == m_cmp);
      n_cnt = v;
    end
    if (stop) n_run = 0;
    if (wr) begin
      case (a)
        3'd0: begin n_cnt = d; ovf_ev = 0; cmp_ev = 0; n_run = m_run; end
        3'd1: n_ar = d;
        3'd2: begin n_run = d[0]; n_down = d[1]; n_ien = d[2]; n_os = d[3]; end
        3'd3: begin n_ovf = m_ovf & ~d[0]; n_cmpf = m_cmpf & ~d[1]; end
        3'd4: begin n_pre = d; n_pcnt = 0; end
        3'd5: n_cmp = d;
        default: ;
      endcase
    end
    n_ovf  = n_ovf | ovf_ev;
    n_cmpf = n_cmpf | cmp_ev;

    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      m_cnt = n_cnt; m_ar = n_ar; m_pre = n_pre; m_cmp = n_cmp; m_pcnt = n_pcnt;
      m_run = n_run; m_down = n_down; m_ien = n_ien; m_os = n_os;
      m_ovf = n_ovf; m_cmpf = n_cmpf;
    end
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a, input int n);
    for (int k = 0; k < n; k++) bus_cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic reset_mid();
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 8; k++) bus_cycle(1'b1, 1'b0, 3'(k), 32'h0);
    reset = 1'b1;
  endtask

  // Monitor: the bus returns data every cycle, so each negedge consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      txn++;
      if (dout !== e.d || irq !== e.i) begin
        errors++;
        $display("FAIL bus_read txn=%0d addr=%0d cs=%0b: got dout=%h irq=%b, want dout=%h irq=%b",
                 txn, e.a, e.c, dout, irq, e.d, e.i);
      end else begin
        $display("txn %0d addr=%0d cs=%0b dout=%h irq=%b", txn, e.a, e.c, dout, irq);
      end
    end
  end

  initial begin
    reset = 1'b0; cs = 0; wen = 0; addr = 0; din = 0;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) bus_cycle(1'b1, 1'b0, 3'(k), 32'h0);
    reset = 1'b1;

    // Up count with reload and interrupt, then W1C of ovf
    wr_reg(3'd4, 0); wr_reg(3'd1, 3); wr_reg(3'd5, 32'h55); wr_reg(3'd2, 32'h5);
    rd_reg(3'd0, 5); rd_reg(3'd3, 1);
    wr_reg(3'd2, 32'h4); wr_reg(3'd3, 1); rd_reg(3'd3, 2);

    // Prescaled down count
    wr_reg(3'd2, 0); wr_reg(3'd3, 3);
    wr_reg(3'd4, 2); wr_reg(3'd0, 2); wr_reg(3'd1, 5); wr_reg(3'd2, 32'h3);
    rd_reg(3'd0, 10); rd_reg(3'd3, 1);

    // Oneshot
    wr_reg(3'd2, 0); wr_reg(3'd3, 3); wr_reg(3'd4, 0); wr_reg(3'd0, 0);
    wr_reg(3'd1, 1); wr_reg(3'd2, 32'h9);
    rd_reg(3'd0, 14); rd_reg(3'd2, 1);

    // Collisions with CMP=2
    wr_reg(3'd2, 0); wr_reg(3'd3, 3); wr_reg(3'd5, 2); wr_reg(3'd1, 10);
    wr_reg(3'd0, 0); wr_reg(3'd2, 32'h1);
    wr_reg(3'd0, 7); rd_reg(3'd3, 1); rd_reg(3'd0, 1);
    wr_reg(3'd0, 0); rd_reg(3'd0, 1); wr_reg(3'd3, 2); rd_reg(3'd3, 1);

    // Bus select and unused slots
    bus_cycle(1'b0, 1'b1, 3'd1, 32'h1234); bus_cycle(1'b0, 1'b0, 3'd1, 0);
    rd_reg(3'd1, 1); rd_reg(3'd6, 1); wr_reg(3'd6, 32'hDEAD); rd_reg(3'd6, 1); rd_reg(3'd7, 1);
    rd_reg(3'd3, 4);

    reset_mid();

    for (int n = 0; n < 1500; n++) begin
      logic        c, w;
      logic [2:0]  a;
      logic [31:0] d;
      c = ($urandom % 8) != 0;
      w = ($urandom % 3) == 0;
      a = 3'($urandom % 8);
      d = (($urandom % 5) == 0) ? $urandom : $urandom_range(0, 6);
      if (a == 3'd2) d = $urandom % 16;
      if (($urandom % 400) == 0) reset_mid();
      else bus_cycle(c, w, a, d);
    end

    cs = 0; wen = 0;
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
